// File: rtl/ifu_fetch.sv
// Instruction fetch unit: AXI-lite read master toward the instruction SRAM.
// It has one outstanding AR at a time and hands {inst, pc} to decode over valid/ready.
module ifu_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000,
  parameter logic [DATA_W-1:0] INST_NOP = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_err
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_OUT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ar_addr;
  logic [ADDR_W-1:0] inst_pc_q;
  logic [DATA_W-1:0] inst_buf;
  logic              kill;
  logic              err_q;
  logic [ADDR_W-1:0] redir_tgt;

  assign redir_tgt  = {redirect_pc[ADDR_W-1:2], 2'b00};

  assign arvalid    = (state == S_AR);
  assign rready     = (state == S_R);
  assign inst_valid = (state == S_OUT);
  assign araddr     = ar_addr;
  assign inst       = inst_valid ? inst_buf : INST_NOP;
  assign inst_pc    = inst_pc_q;
  assign inst_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      ar_addr   <= RESET_PC;
      inst_pc_q <= RESET_PC;
      inst_buf  <= INST_NOP;
      kill      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_AR;
          if (redirect_valid) begin
            pc      <= redir_tgt;
            ar_addr <= redir_tgt;
          end else begin
            ar_addr <= pc;
          end
        end
        // The presented address must not change before the handshake, so a
        // redirect here only marks the in-flight beat for discard.
        S_AR: begin
          if (redirect_valid) begin
            pc   <= redir_tgt;
            kill <= 1'b1;
          end
          if (arready) state <= S_R;
        end
        S_R: begin
          if (rvalid) begin
            if (kill || redirect_valid) begin
              kill  <= 1'b0;
              state <= S_AR;
              if (redirect_valid) begin
                pc      <= redir_tgt;
                ar_addr <= redir_tgt;
              end else begin
                ar_addr <= pc;
              end
            end else begin
              inst_buf  <= rdata;
              inst_pc_q <= ar_addr;
              err_q     <= (rresp != 2'b00);
              pc        <= ar_addr + ADDR_W'(4);
              state     <= S_OUT;
            end
          end else if (redirect_valid) begin
            pc   <= redir_tgt;
            kill <= 1'b1;
          end
        end
        // A redirect beats a simultaneous inst_ready: the held instruction is dropped.
        S_OUT: begin
          if (redirect_valid) begin
            pc      <= redir_tgt;
            ar_addr <= redir_tgt;
            state   <= S_AR;
          end else if (inst_ready) begin
            ar_addr <= pc;
            state   <= S_AR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: table of fetch vectors with an AR-to-inst scoreboard,
// plus directed redirect, wrap and mid-transaction reset sequences.
module tb_ifu_fetch;
  localparam int          ADDR_W   = 32;
  localparam int          DATA_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready = 1'b0;
  logic [DATA_W-1:0] rdata = '0;
  logic [1:0]        rresp = 2'b00;
  logic              rvalid = 1'b0;
  logic              rready;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              inst_valid;
  logic              inst_ready = 1'b0;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_err;

  ifu_fetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(RESET_PC), .INST_NOP(INST_NOP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ar_wait;
    int          r_wait;
    int          rdy_wait;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [31:0] exp_addr;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_arvalid(input string tag);
    int c = 0;
    while (arvalid !== 1'b1 && c < 50) begin
      tick();
      c++;
    end
    if (arvalid !== 1'b1) check({tag, "_arvalid_timeout"}, 32'(arvalid), 32'd1);
  endtask

  task automatic do_fetch(input vec_t v, input string tag);
    int          lat;
    int          c;
    logic [31:0] a0;
    logic        ok;
    exp_t        e;
    exp_t        got;
    wait_arvalid(tag);
    lat = 0;
    check({tag, "_araddr"}, araddr, v.exp_addr);
    a0 = araddr;
    ok = 1'b1;
    for (int i = 0; i < v.ar_wait; i++) begin
      tick();
      lat++;
      if (arvalid !== 1'b1 || araddr !== a0) ok = 1'b0;
    end
    check({tag, "_ar_hold"}, 32'(ok), 32'd1);
    arready = 1'b1;
    e.inst = v.rdata;
    e.pc   = v.exp_addr;
    e.err  = v.exp_err;
    sb.push_back(e);
    tick();
    lat++;
    arready = 1'b0;
    check({tag, "_r_state"}, {30'b0, arvalid, rready}, 32'd1);
    for (int i = 0; i < v.r_wait; i++) begin
      tick();
      lat++;
    end
    rvalid = 1'b1;
    rdata  = v.rdata;
    rresp  = v.rresp;
    tick();
    lat++;
    rvalid = 1'b0;
    rdata  = 32'h5A5A_5A5A;
    rresp  = 2'b00;
    c = 0;
    while (inst_valid !== 1'b1 && c < 50) begin
      tick();
      c++;
      lat++;
    end
    check({tag, "_inst_valid"}, 32'(inst_valid), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(2 + v.ar_wait + v.r_wait));
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      got = sb.pop_front();
      check({tag, "_inst"}, inst, got.inst);
      check({tag, "_inst_pc"}, inst_pc, got.pc);
      check({tag, "_inst_err"}, 32'(inst_err), 32'(got.err));
    end
    ok = 1'b1;
    for (int i = 0; i < v.rdy_wait; i++) begin
      tick();
      if (inst_valid !== 1'b1 || inst !== v.rdata || inst_pc !== v.exp_addr || arvalid !== 1'b0)
        ok = 1'b0;
    end
    check({tag, "_out_hold"}, 32'(ok), 32'd1);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check({tag, "_after_ready_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_after_ready_nop"}, inst, INST_NOP);
  endtask

  // Redirect while waiting for R: the later beat must vanish.
  task automatic seq_redir_r(input logic [31:0] old_addr);
    wait_arvalid("redir_r");
    check("redir_r_araddr", araddr, old_addr);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    check("redir_r_rready", 32'(rready), 32'd1);
    rvalid = 1'b1;
    rdata  = 32'hBAD0_0001;
    tick();
    rvalid = 1'b0;
    check("redir_r_drop", 32'(inst_valid), 32'd0);
    check("redir_r_arvalid", 32'(arvalid), 32'd1);
    check("redir_r_next", araddr, 32'h8000_0100);
  endtask

  task automatic seq_out_redirect();
    wait_arvalid("out_rd");
    check("out_rd_araddr", araddr, 32'h8000_0104);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'h0060_0313;
    tick();
    rvalid = 1'b0;
    check("out_rd_valid", 32'(inst_valid), 32'd1);
    check("out_rd_pc", inst_pc, 32'h8000_0104);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_2003;
    tick();
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    check("out_rd_dropped", 32'(inst_valid), 32'd0);
    check("out_rd_next", araddr, 32'h8000_2000);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid         = 1'b1;
    rdata          = 32'hBAD0_0002;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_3000;
    tick();
    rvalid         = 1'b0;
    redirect_valid = 1'b0;
    check("rv_rd_drop", 32'(inst_valid), 32'd0);
    check("rv_rd_arvalid", 32'(arvalid), 32'd1);
    check("rv_rd_next", araddr, 32'h8000_3000);
  endtask

  // Redirect during AR: old request completes unchanged, its beat is discarded.
  task automatic seq_redir_ar(input logic [31:0] old_addr, input logic [31:0] new_addr, input string tag);
    wait_arvalid(tag);
    check({tag, "_araddr"}, araddr, old_addr);
    redirect_valid = 1'b1;
    redirect_pc    = new_addr;
    tick();
    redirect_valid = 1'b0;
    check({tag, "_ar_stable"}, araddr, old_addr);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'hBAD0_0003;
    tick();
    rvalid = 1'b0;
    check({tag, "_drop"}, 32'(inst_valid), 32'd0);
    check({tag, "_next"}, araddr, new_addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[9];
    vecs[0] = '{0, 0, 0, 32'h0010_0093, 2'b00, 32'h8000_0000, 1'b0};
    vecs[1] = '{5, 0, 0, 32'h0020_0113, 2'b00, 32'h8000_0004, 1'b0};
    vecs[2] = '{0, 2, 4, 32'h0030_0193, 2'b00, 32'h8000_0008, 1'b0};
    vecs[3] = '{0, 1, 0, 32'hDEAD_BEEF, 2'b10, 32'h8000_000C, 1'b1};
    vecs[4] = '{0, 0, 0, 32'h1111_1111, 2'b11, 32'h8000_0010, 1'b1};
    vecs[5] = '{0, 0, 0, 32'h0050_0293, 2'b00, 32'h8000_0100, 1'b0};
    vecs[6] = '{1, 1, 1, 32'h0070_0393, 2'b00, 32'h8000_4000, 1'b0};
    vecs[7] = '{0, 0, 0, 32'h0000_0073, 2'b00, 32'hFFFF_FFFC, 1'b0};
    vecs[8] = '{0, 0, 0, 32'h0000_1111, 2'b00, 32'h0000_0000, 1'b0};

    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, INST_NOP);
    check("rst_inst_err", 32'(inst_err), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_arvalid_first", 32'(arvalid), 32'd1);

    for (int i = 0; i < 9; i++) begin
      do_fetch(vecs[i], $sformatf("v%0d", i));
      case (i)
        4: seq_redir_r(32'h8000_0014);
        5: begin
          seq_out_redirect();
          seq_redir_ar(32'h8000_3000, 32'h8000_4000, "ar_rd");
        end
        6: seq_redir_ar(32'h8000_4004, 32'hFFFF_FFFC, "wrap_rd");
        default: ;
      endcase
    end

    // Reset in the middle of an R wait clears everything asynchronously.
    wait_arvalid("midrst");
    check("midrst_araddr", araddr, 32'h0000_0004);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rready", 32'(rready), 32'd0);
    check("midrst_arvalid", 32'(arvalid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_restart_valid", 32'(arvalid), 32'd1);
    check("midrst_restart_addr", araddr, RESET_PC);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
